// File: rtl/button_seq_pkg.sv
// rtl/button_seq_pkg.sv - shared states, PIO register map and helpers for the button sequencer
package button_seq_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_MASK_WR,
        S_RD_CAP,
        S_CAP_WAIT,
        S_CLR,
        S_RD_DAT,
        S_DAT_WAIT,
        S_EMIT,
        S_HOLD,
        S_FLUSH
    } state_e;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/button_pio_sequencer_holdoff_timer.sv
// rtl/button_pio_sequencer_holdoff_timer.sv - debounce holdoff down-counter with single-cycle done pulse
module button_holdoff_timer #(
    parameter int HOLDOFF_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic start_i,
    output logic done_o
);

    localparam int CW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic          run_q;

    // start_i marks the first holdoff cycle; done_o fires in the last one.
    always_comb begin
        done_o = 1'b0;
        if (start_i) begin
            done_o = (HOLDOFF_CYCLES <= 1);
        end else begin
            done_o = run_q && (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i && (HOLDOFF_CYCLES > 1)) begin
            cnt_q <= CW'(HOLDOFF_CYCLES - 1);
            run_q <= 1'b1;
        end else if (done_o) begin
            run_q <= 1'b0;
        end else if (run_q && (cnt_q > CW'(1))) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/button_pio_sequencer.sv
// rtl/button_pio_sequencer.sv - Avalon-MM master servicing an edge-capturing button PIO
module button_pio_sequencer
    import button_seq_pkg::*;
#(
    parameter int            DW             = 8,
    parameter logic [DW-1:0] INIT_MASK      = 8'hFF,
    parameter int            HOLDOFF_CYCLES = 500000,
    parameter bit            ACTIVE_LOW     = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] cfg_mask,
    input  logic          cfg_load,
    output logic [1:0]    pio_address,
    output logic          pio_chipselect,
    output logic          pio_write_n,
    output logic [DW-1:0] pio_writedata,
    input  logic [DW-1:0] pio_readdata,
    input  logic          pio_irq,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [2:0]    evt_index,
    output logic          evt_pressed,
    output logic          busy
);

    state_e        state_q;
    logic          cs_q, wn_q, busy_q;
    logic [1:0]    addr_q;
    logic [DW-1:0] wdata_q, cap_q, data_q, mask_lat_q, cap_d;
    logic          mask_pend_q, hold_start_q, hold_done;
    logic          evt_valid_q, evt_pressed_q;
    logic [2:0]    evt_index_q, first_idx, next_idx;

    always_comb begin
        cap_d     = cap_q & ~(DW'(1) << evt_index_q);
        first_idx = lowest_set(8'(cap_q));
        next_idx  = lowest_set(8'(cap_d));
    end

    button_holdoff_timer #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_timer (
        .clk_i   (clk),
        .resetn_i(reset_n),
        .start_i (hold_start_q),
        .done_o  (hold_done)
    );

    // All outputs are registered, so each state's bus cycle appears one cycle after the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_INIT;
            cs_q          <= 1'b0;
            wn_q          <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            evt_valid_q   <= 1'b0;
            evt_index_q   <= '0;
            evt_pressed_q <= 1'b0;
            busy_q        <= 1'b1;
            cap_q         <= '0;
            data_q        <= '0;
            mask_lat_q    <= '0;
            mask_pend_q   <= 1'b0;
            hold_start_q  <= 1'b0;
        end else begin
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            hold_start_q <= 1'b0;
            busy_q       <= (state_q != S_IDLE);
            case (state_q)
                S_INIT: begin
                    {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, ADDR_MASK, INIT_MASK};
                    state_q <= S_IDLE;
                end
                S_IDLE: begin
                    // irq is stale while a clear/mask write is still on the bus
                    if (mask_pend_q) begin
                        state_q <= S_MASK_WR;
                    end else if (pio_irq && !(cs_q && !wn_q)) begin
                        state_q <= S_RD_CAP;
                    end
                end
                S_MASK_WR: begin
                    {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, ADDR_MASK, mask_lat_q};
                    mask_pend_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                S_RD_CAP: begin
                    cs_q    <= 1'b1;
                    addr_q  <= ADDR_CAP;
                    state_q <= S_CAP_WAIT;
                end
                S_CAP_WAIT: begin
                    cs_q    <= 1'b1;
                    state_q <= S_CLR;
                end
                S_CLR: begin
                    cap_q <= pio_readdata;
                    {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, ADDR_CAP, {DW{1'b0}}};
                    state_q <= S_RD_DAT;
                end
                S_RD_DAT: begin
                    cs_q    <= 1'b1;
                    addr_q  <= ADDR_DATA;
                    state_q <= S_DAT_WAIT;
                end
                S_DAT_WAIT: begin
                    cs_q    <= 1'b1;
                    state_q <= S_EMIT;
                end
                S_EMIT: begin
                    if (!evt_valid_q) begin
                        data_q <= pio_readdata;
                        if (cap_q == '0) begin
                            state_q      <= (HOLDOFF_CYCLES == 0) ? S_FLUSH : S_HOLD;
                            hold_start_q <= 1'b1;
                        end else begin
                            evt_valid_q   <= 1'b1;
                            evt_index_q   <= first_idx;
                            evt_pressed_q <= pio_readdata[first_idx] ^ ACTIVE_LOW;
                        end
                    end else if (evt_ready) begin
                        cap_q <= cap_d;
                        if (cap_d == '0) begin
                            evt_valid_q  <= 1'b0;
                            state_q      <= (HOLDOFF_CYCLES == 0) ? S_FLUSH : S_HOLD;
                            hold_start_q <= 1'b1;
                        end else begin
                            evt_index_q   <= next_idx;
                            evt_pressed_q <= data_q[next_idx] ^ ACTIVE_LOW;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_done) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, ADDR_CAP, {DW{1'b0}}};
                    state_q <= S_IDLE;
                end
                default: state_q <= S_INIT;
            endcase
            if (cfg_load) begin
                mask_lat_q  <= cfg_mask;
                mask_pend_q <= 1'b1;
            end
        end
    end

    assign pio_address    = addr_q;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_writedata  = wdata_q;
    assign evt_valid      = evt_valid_q;
    assign evt_index      = evt_index_q;
    assign evt_pressed    = evt_pressed_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_button_pio_sequencer.sv
// tb/tb_button_pio_sequencer.sv - scoreboard bench with a PIO model and randomized button passes
module tb_button_pio_sequencer;

    localparam int HOLD = 20;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic       flush;
    } op_t;

    typedef struct {
        logic [2:0] idx;
        logic       pressed;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n, cfg_load, pio_chipselect, pio_write_n, pio_irq;
    logic       evt_valid, evt_ready, evt_pressed, busy;
    logic [7:0] cfg_mask, pio_writedata, pio_readdata;
    logic [1:0] pio_address;
    logic [2:0] evt_index;

    logic [7:0] m_cap = 8'h00, m_mask = 8'h00, m_data, inject;
    logic       spur;

    int  passed = 0, total = 0, cyc = 0, last_act = 0, flush_cnt = 0, ready_mode = 1;
    op_t opq[$];
    ev_t evq[$];

    always #5 clk = ~clk;

    button_pio_sequencer #(
        .DW(8), .INIT_MASK(8'hFF), .HOLDOFF_CYCLES(HOLD), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_mask(cfg_mask), .cfg_load(cfg_load),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata), .pio_readdata(pio_readdata), .pio_irq(pio_irq),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
        .evt_pressed(evt_pressed), .busy(busy)
    );

    // Edge-capturing PIO: a write to the capture register wins over a new edge.
    assign pio_irq = (|(m_cap & m_mask)) | spur;
    always @(posedge clk) begin
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3) m_cap <= 8'h00;
        else m_cap <= m_cap | inject;
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2) m_mask <= pio_writedata;
        case (pio_address)
            2'd0:    pio_readdata <= m_data;
            2'd2:    pio_readdata <= m_mask;
            2'd3:    pio_readdata <= m_cap;
            default: pio_readdata <= 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d required %0d", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_op(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                           input logic flush);
        opq.push_back(op_t'{wr: wr, addr: addr, data: data, flush: flush});
    endtask

    // Expected traffic for one service pass, derived from the bus protocol and event rules.
    task automatic do_pass(input logic [7:0] cap, input logic [7:0] data);
        m_data = data;
        push_op(1'b0, 2'd3, 8'h00, 1'b0);
        push_op(1'b0, 2'd3, 8'h00, 1'b0);
        push_op(1'b1, 2'd3, 8'h00, 1'b0);
        push_op(1'b0, 2'd0, 8'h00, 1'b0);
        push_op(1'b0, 2'd0, 8'h00, 1'b0);
        push_op(1'b1, 2'd3, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++)
            if (cap[i]) evq.push_back(ev_t'{idx: 3'(i), pressed: ~data[i]});
        inject = cap;
        tick();
        inject = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(opq.size() == 0 && evq.size() == 0 && busy == 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            total++;
            $display("FAIL %s_timeout: %0d ops and %0d events still pending, required 0",
                     name, opq.size(), evq.size());
            opq.delete();
            evq.delete();
        end
        repeat (5) tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!evt_valid && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            total++;
            $display("FAIL %s_timeout: evt_valid got 0 required 1", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_chipselect"}, pio_chipselect, 0);
        chk({tag, "_write_n"}, pio_write_n, 1);
        chk({tag, "_address"}, pio_address, 0);
        chk({tag, "_writedata"}, pio_writedata, 0);
        chk({tag, "_evt_valid"}, evt_valid, 0);
        chk({tag, "_evt_index"}, evt_index, 0);
        chk({tag, "_evt_pressed"}, evt_pressed, 0);
        chk({tag, "_busy"}, busy, 1);
    endtask

    initial begin
        evt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       evt_ready = ($urandom_range(0, 3) != 0);
                1:       evt_ready = 1'b1;
                default: evt_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted event and every bus cycle.
    initial begin
        logic       hold_prev;
        logic [2:0] pidx;
        logic       pprs;
        op_t        o;
        ev_t        e;
        hold_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                if (hold_prev) begin
                    chk("stall_valid", evt_valid, 1);
                    chk("stall_index", evt_index, pidx);
                    chk("stall_pressed", evt_pressed, pprs);
                end
                hold_prev = evt_valid && !evt_ready;
                pidx = evt_index;
                pprs = evt_pressed;
                if (evt_valid && evt_ready) begin
                    if (evq.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_event: got index %0d, no event expected", evt_index);
                    end else begin
                        e = evq.pop_front();
                        chk("event_index", evt_index, e.idx);
                        chk("event_pressed", evt_pressed, e.pressed);
                    end
                    last_act = cyc;
                end
                if (pio_chipselect) begin
                    if (opq.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_bus: got addr %0d write_n %0d, no cycle expected",
                                 pio_address, pio_write_n);
                    end else begin
                        o = opq.pop_front();
                        chk("bus_is_write", !pio_write_n, o.wr);
                        chk("bus_address", pio_address, o.addr);
                        if (o.wr) chk("bus_writedata", pio_writedata, o.data);
                        if (o.flush) begin
                            // last activity, HOLD cycles, FLUSH cycle, then the write itself
                            chk("flush_gap", cyc - last_act, HOLD + 2);
                            flush_cnt++;
                        end
                    end
                    last_act = cyc;
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0;
        reset_n = 1'b0; cfg_load = 1'b0; cfg_mask = 8'h00;
        m_data = 8'h00; inject = 8'h00; spur = 1'b0;
        repeat (3) tick();
        cfg_load = 1'b1; cfg_mask = 8'h55;
        tick();
        cfg_load = 1'b0;
        check_reset_outputs("reset");
        push_op(1'b1, 2'd2, 8'hFF, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("init_write_cs", pio_chipselect, 1);
        chk("init_busy_high", busy, 1);
        tick();
        chk("init_busy_low", busy, 0);
        wait_idle("init");

        ready_mode = 1;
        do_pass(8'b0000_0101, 8'b1111_1010);
        wait_idle("directed");

        ready_mode = 2;
        do_pass(8'b0000_0101, 8'($urandom));
        wait_valid("stall");
        repeat (5) begin
            tick();
            chk("stall5_valid", evt_valid, 1);
            chk("stall5_index", evt_index, 0);
        end
        ready_mode = 0;
        wait_idle("stall");

        do_pass(8'($urandom_range(1, 255)), 8'($urandom));
        n = 0;
        while (!(evq.size() == 0 && opq.size() == 1) && n < 500) begin
            tick();
            n++;
        end
        repeat (2) tick();
        repeat (3) begin
            inject = 8'($urandom_range(1, 255));
            tick();
            inject = 8'h00;
            tick();
        end
        wait_idle("bounce");
        chk("bounce_busy", busy, 0);

        repeat (6) begin
            do_pass(8'($urandom_range(1, 255)), 8'($urandom));
            wait_idle("random");
        end

        ready_mode = 2;
        do_pass(8'($urandom_range(1, 255)) | 8'h40, 8'($urandom));
        wait_valid("cfg");
        f0 = flush_cnt;
        cfg_load = 1'b1; cfg_mask = 8'h0F;
        tick();
        cfg_mask = 8'h03;
        tick();
        cfg_load = 1'b0;
        push_op(1'b1, 2'd2, 8'h03, 1'b0);
        ready_mode = 0;
        n = 0;
        while (flush_cnt == f0 && n < 500) begin
            tick();
            n++;
        end
        tick();
        do_pass(8'($urandom_range(1, 3)), 8'($urandom));
        wait_idle("cfg");

        do_pass(8'($urandom_range(1, 3)), 8'($urandom));
        n = 0;
        while (!(pio_chipselect && pio_write_n && pio_address == 2'd0) && n < 500) begin
            tick();
            n++;
        end
        reset_n = 1'b0;
        opq.delete();
        evq.delete();
        tick();
        check_reset_outputs("midreset");
        push_op(1'b1, 2'd2, 8'hFF, 1'b0);
        reset_n = 1'b1;
        wait_idle("midreset");

        push_op(1'b0, 2'd3, 8'h00, 1'b0);
        push_op(1'b0, 2'd3, 8'h00, 1'b0);
        push_op(1'b1, 2'd3, 8'h00, 1'b0);
        push_op(1'b0, 2'd0, 8'h00, 1'b0);
        push_op(1'b0, 2'd0, 8'h00, 1'b0);
        push_op(1'b1, 2'd3, 8'h00, 1'b1);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        wait_idle("spurious");
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
